// File: rtl/nf10_axis_pkg.sv
// nf10_axis_pkg
// Shared definitions for the NF10 AXI-Stream egress path:
//   - tuser field offsets (len / spt / dpt positions)
//   - egress filter FSM state encoding
//   - byte-enable popcount helper
package nf10_axis_pkg;

    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_W   = 16;
    localparam int TUSER_SPT_LSB = 16;
    localparam int TUSER_SPT_W   = 8;
    localparam int TUSER_DPT_LSB = 24;
    localparam int TUSER_DPT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } egress_state_e;

    // Number of enabled bytes in one 64-bit beat.
    function automatic logic [3:0] strb_popcount(input logic [7:0] strb);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, strb[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/nf10_axis_skid_reg.sv
// nf10_axis_skid_reg
// Generic two-entry AXI-Stream register slice (data + strb + last).
// One output register plus one skid entry; in_ready comes from a flop,
// so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_data/in_strb/in_last       upstream beat
//   in_valid / in_ready           upstream handshake
//   out_data/out_strb/out_last    downstream beat (registered)
//   out_valid / out_ready         downstream handshake
module nf10_axis_skid_reg #(
    parameter int C_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_DATA_WIDTH-1:0]   in_data,
    input  logic [C_DATA_WIDTH/8-1:0] in_strb,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [C_DATA_WIDTH-1:0]   out_data,
    output logic [C_DATA_WIDTH/8-1:0] out_strb,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int BEAT_W = C_DATA_WIDTH + STRB_W + 1;

    logic [BEAT_W-1:0] out_beat_q, out_beat_d;
    logic [BEAT_W-1:0] skid_beat_q, skid_beat_d;
    logic              out_valid_q, out_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              ready_q, ready_d;
    logic              in_fire_s;
    logic              out_fire_s;
    logic [BEAT_W-1:0] in_beat_s;

    assign in_beat_s = {in_last, in_strb, in_data};

    // Slice next-state: refill the output register from skid first, else from input
    always_comb begin
        out_beat_d   = out_beat_q;
        skid_beat_d  = skid_beat_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        in_fire_s    = in_valid & ready_q;
        out_fire_s   = out_valid_q & out_ready;
        if (!out_valid_q || out_fire_s) begin
            // in_ready is low whenever skid holds a beat, so at most one source is live here
            if (skid_valid_q) begin
                out_beat_d   = skid_beat_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                out_beat_d  = in_beat_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_beat_d  = in_beat_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        ready_d = ~skid_valid_d;
    end

    // Slice registers; ready stays low through reset and rises one cycle after release
    always_ff @(posedge clk) begin
        if (rst) begin
            out_beat_q   <= {BEAT_W{1'b0}};
            skid_beat_q  <= {BEAT_W{1'b0}};
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_beat_q   <= out_beat_d;
            skid_beat_q  <= skid_beat_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_beat_q[BEAT_W-1];
    assign out_strb  = out_beat_q[C_DATA_WIDTH +: STRB_W];
    assign out_data  = out_beat_q[C_DATA_WIDTH-1:0];

endmodule

// File: rtl/nf10_axis_egress_filter.sv
// nf10_axis_egress_filter
// Per-port egress gate. On the first beat of each packet the dst-port field
// of tuser is tested against C_PORT_MASK: matching packets are forwarded
// (tuser stripped) through a registered skid slice, others are drained.
// Optional macro NF10_EGRESS_STATS_EN builds pass/drop/length-error
// counters and the byte counter; without it stat_* read zero.
// Ports:
//   axi_aclk, axi_reset           clock, synchronous active-high reset
//   s_axis_*                      input stream (tuser = {.., dpt, spt, len})
//   m_axis_*                      output stream to the MAC (no tuser)
//   stat_pkt_pass/drop/len_err    32-bit wrapping statistics
module nf10_axis_egress_filter
    import nf10_axis_pkg::*;
#(
    parameter int                    C_DATA_WIDTH  = 64,
    parameter int                    C_TUSER_WIDTH = 128,
    parameter int                    C_LEN_WIDTH   = 16,
    parameter int                    C_SPT_WIDTH   = 8,
    parameter int                    C_DPT_WIDTH   = 8,
    parameter logic [C_DPT_WIDTH-1:0] C_PORT_MASK  = 8'h01
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [31:0]               stat_pkt_pass,
    output logic [31:0]               stat_pkt_drop,
    output logic [31:0]               stat_len_err
);

    egress_state_e          state_q, state_d;
    logic                   skid_ready_s;
    logic                   fwd_s;
    logic                   first_s;
    logic                   accept_s;
    logic                   skid_in_valid_s;
    logic [C_DPT_WIDTH-1:0] dpt_s;
    logic [C_LEN_WIDTH-1:0] len_in_s;

    assign dpt_s    = s_axis_tuser[TUSER_DPT_LSB +: C_DPT_WIDTH];
    assign len_in_s = s_axis_tuser[TUSER_LEN_LSB +: C_LEN_WIDTH];

    // Next-state and input-side handshake decode
    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        fwd_s         = 1'b0;
        first_s       = 1'b0;
        accept_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_axis_tready = skid_ready_s;
                first_s       = 1'b1;
                if ((dpt_s & C_PORT_MASK) != {C_DPT_WIDTH{1'b0}}) begin
                    fwd_s = 1'b1;
                end else begin
                    fwd_s = 1'b0;
                end
                accept_s = s_axis_tvalid & s_axis_tready;
                // single-beat packets never leave IDLE
                if (accept_s && !s_axis_tlast) begin
                    if (fwd_s) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                s_axis_tready = skid_ready_s;
                fwd_s         = 1'b1;
                accept_s      = s_axis_tvalid & s_axis_tready;
                if (accept_s && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_DROP: begin
                // draining never waits on the output stage
                s_axis_tready = 1'b1;
                accept_s      = s_axis_tvalid;
                if (accept_s && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign skid_in_valid_s = s_axis_tvalid & fwd_s;

    nf10_axis_skid_reg #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_skid (
        .clk       (axi_aclk),
        .rst       (axi_reset),
        .in_data   (s_axis_tdata),
        .in_strb   (s_axis_tstrb),
        .in_last   (s_axis_tlast),
        .in_valid  (skid_in_valid_s),
        .in_ready  (skid_ready_s),
        .out_data  (m_axis_tdata),
        .out_strb  (m_axis_tstrb),
        .out_last  (m_axis_tlast),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

`ifdef NF10_EGRESS_STATS_EN
    logic [C_LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [C_LEN_WIDTH-1:0] len_q, len_d;
    logic [31:0]            pass_q, pass_d;
    logic [31:0]            drop_q, drop_d;
    logic [31:0]            err_q, err_d;
    logic [C_LEN_WIDTH-1:0] pop_s;
    logic [C_LEN_WIDTH:0]   sum_s;
    logic [C_LEN_WIDTH-1:0] cnt_now_s;
    logic [C_LEN_WIDTH-1:0] len_now_s;
    logic                   unused_s;

    assign unused_s = ^{s_axis_tuser[C_TUSER_WIDTH-1:TUSER_DPT_LSB+C_DPT_WIDTH],
                        s_axis_tuser[TUSER_SPT_LSB +: C_SPT_WIDTH]};

    // Byte count including the current beat (first beat loads, later beats saturate-add) and stats update
    always_comb begin
        cnt_d  = cnt_q;
        len_d  = len_q;
        pass_d = pass_q;
        drop_d = drop_q;
        err_d  = err_q;
        pop_s  = {{(C_LEN_WIDTH-4){1'b0}}, strb_popcount(s_axis_tstrb)};
        sum_s  = {1'b0, cnt_q} + {1'b0, pop_s};
        if (first_s) begin
            cnt_now_s = pop_s;
            len_now_s = len_in_s;
        end else begin
            if (sum_s[C_LEN_WIDTH]) begin
                cnt_now_s = {C_LEN_WIDTH{1'b1}};
            end else begin
                cnt_now_s = sum_s[C_LEN_WIDTH-1:0];
            end
            len_now_s = len_q;
        end
        if (accept_s && fwd_s) begin
            cnt_d = cnt_now_s;
            len_d = len_now_s;
            if (s_axis_tlast) begin
                pass_d = pass_q + 32'd1;
                if (cnt_now_s != len_now_s) begin
                    err_d = err_q + 32'd1;
                end else begin
                    err_d = err_q;
                end
            end else begin
                pass_d = pass_q;
            end
        end else if (accept_s && s_axis_tlast) begin
            drop_d = drop_q + 32'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Statistics registers
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            cnt_q  <= {C_LEN_WIDTH{1'b0}};
            len_q  <= {C_LEN_WIDTH{1'b0}};
            pass_q <= 32'd0;
            drop_q <= 32'd0;
            err_q  <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            pass_q <= pass_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

    assign stat_pkt_pass = pass_q;
    assign stat_pkt_drop = drop_q;
    assign stat_len_err  = err_q;
`else
    logic unused_s;

    assign unused_s = ^{s_axis_tuser[C_TUSER_WIDTH-1:TUSER_DPT_LSB+C_DPT_WIDTH],
                        s_axis_tuser[TUSER_SPT_LSB +: C_SPT_WIDTH],
                        len_in_s, first_s, accept_s};

    assign stat_pkt_pass = 32'h0;
    assign stat_pkt_drop = 32'h0;
    assign stat_len_err  = 32'h0;
`endif

endmodule

// File: doc/nf10_axis_egress_filter.md
# nf10_axis_egress_filter

Per-port egress gate placed directly downstream of the 256→64-bit AXI-Stream width converter, feeding the 10G MAC transmit interface. It inspects the destination-port field of the 128-bit tuser on each packet's first beat and does one of two things. It forwards the packet through a registered skid stage, with tuser stripped, when the port bit matches. Otherwise it silently drains the packet. It also checks the byte count against the tuser length field and, optionally, keeps per-port statistics.

## Interface
Parameters:
- C_DATA_WIDTH, 64, stream data width (tstrb width = C_DATA_WIDTH/8)
- C_TUSER_WIDTH, 128, input sideband width
- C_LEN_WIDTH, 16, length field at tuser[15:0]
- C_SPT_WIDTH, 8, source-port field at tuser[23:16]
- C_DPT_WIDTH, 8, destination-port field at tuser[31:24]
- C_PORT_MASK, 8'h01, one-hot dst-port bit(s) owned by this egress

Ports:
- axi_aclk  in  1  clock
- axi_reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  64  input data
- s_axis_tstrb  in  8  input byte enables
- s_axis_tuser  in  128  {.., dpt, spt, len}; meaningful on first beat only
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of packet
- m_axis_tdata  out  64  output data
- m_axis_tstrb  out  8  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  end of packet
- stat_pkt_pass  out  32  forwarded-packet count
- stat_pkt_drop  out  32  drained-packet count
- stat_len_err  out  32  length-mismatch count

## Operation
- FSM states: IDLE, PASS, DROP.
- IDLE, accepted beat:
  - If (dpt & C_PORT_MASK) != 0: forward the beat and latch len. Go to PASS unless tlast.
  - Otherwise: consume the beat. Go to DROP unless tlast.
  - A single-beat packet stays in IDLE.
- PASS: forward every accepted beat. On an accepted tlast beat, go to IDLE.
- DROP: s_axis_tready = 1 unconditionally, nothing is emitted. On an accepted tlast beat, go to IDLE.
- Byte counter:
  - 16-bit, saturating at 16'hFFFF.
  - Each accepted beat adds popcount(tstrb). The first beat loads rather than adds.
  - Applies in PASS only.
- At the tlast of a passed packet, if count != latched len, stat_len_err increments. The packet is still forwarded unmodified.
- Counters are 32-bit and wrap 0xFFFFFFFF→0. pass/drop increment on the accepted tlast beat.
- tdata, tstrb and tlast are forwarded bit-exact. tuser is not forwarded.

## Timing
- Output register plus a one-entry skid buffer. Throughput is one beat per cycle sustained.
- Latency: an accepted beat appears on m_axis at the next cycle, or later under backpressure.
- s_axis_tready = !skid_full in IDLE/PASS, 1 in DROP. It depends on registers only, with no combinational path from m_axis_tready.
- m_axis_tvalid, once high, holds with stable data until m_axis_tready.
- m_axis_tready low for N cycles: at most 2 beats are absorbed, then s_axis_tready falls the cycle after skid fill.
- A drop decision does not wait for PASS beats still buffered in the output/skid stage to drain.
- Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0, tdata/tstrb = 0.
  - s_axis_tready = 0 during reset, 1 the cycle after release.
  - FSM = IDLE, skid empty, all stat_* = 0.
- Reset mid-packet discards buffered beats. The next beat after release is treated as a first beat, since upstream shares the reset.

## Configuration
- NF10_EGRESS_STATS_EN:
  - Defined: the three 32-bit counters and the length comparator are built.
  - Undefined: stat_* are tied to 32'h0 and the byte counter is removed.
  - Forwarding and drop behaviour are identical either way.

## Structure
- Shared package (nf10_axis_pkg):
  - tuser field offsets/widths (LEN/SPT/DPT positions)
  - FSM state enum
  - popcount function for tstrb
- One sub-module: nf10_axis_skid_reg. It is the generic 2-entry register slice (data+strb+last), reusable elsewhere in the pipeline.

## Test plan
- C_PORT_MASK=8'h01, 3 back-to-back 8-beat packets with dpt=8'h01, m_axis_tready=1 → 24 beats out contiguously, 1-cycle latency, stat_pkt_pass=3.
- A packet with dpt=8'h04 (5 beats) between two dpt=8'h01 packets → only the two match packets appear; s_axis_tready=1 throughout the drop; stat_pkt_drop=1.
- Single-beat packet, len=8, tstrb=8'hFF, dpt=8'h01 → one beat out with tlast=1; FSM stays IDLE; no len_err.
- Packet len=64 but beats total 60 bytes (last tstrb=8'h0F, 7 full + 1) → forwarded intact, stat_len_err=1.
- Random m_axis_tready (50%) over 100 packets → no beat loss/duplication, tvalid/data stable while stalled, s_axis_tready falls only with skid full.
- axi_reset asserted at beat 3 of a 6-beat PASS packet → m_axis_tvalid=0 next cycle, counters 0. The next packet forwards normally.
